// File: rtl/cmp_sort_ctrl_pkg.sv
// Shared types and constants for the time-shared comparator sort controller.
package cmp_sort_ctrl_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_OUT
    } state_e;

    // Bubble sort without early exit visits every adjacent pair of every pass.
    function automatic int sort_cycles(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/cmp_sort_ctrl_cmp.sv
// Purely combinational 4-bit unsigned magnitude comparator; exactly one output is high.
module cmp_unit_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);

    assign gt_o = (a_i >  b_i);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Loads N values, bubble-sorts them one compare per cycle through a single
// shared 4-bit comparator, then streams them out in ascending order.
module cmp_sort_ctrl
    import cmp_sort_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic [CW-1:0] swap_cnt
);

    localparam int IW = $clog2(N);

    state_e          state_q, state_d;
    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    mem_d [N];
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [CW-1:0]   swap_cnt_q, swap_cnt_d;

    logic [W-1:0]    cmp_a, cmp_b;
    logic            cmp_gt, cmp_eq, cmp_lt;

    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_q + IW'(1)];

    cmp_unit_4bit u_cmp (
        .a_i  (cmp_a),
        .b_i  (cmp_b),
        .gt_o (cmp_gt),
        .eq_o (cmp_eq),
        .lt_o (cmp_lt)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        mem_d      = mem_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        i_d        = i_q;
        j_d        = j_q;
        swap_cnt_d = swap_cnt_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == '0) begin
                        swap_cnt_d = '0;
                    end
                    if (wr_idx_q == IW'(N - 1)) begin
                        state_d  = S_SORT;
                        wr_idx_d = '0;
                        i_d      = '0;
                        j_d      = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end

            S_SORT: begin
                // Equal entries stay in place, which keeps the sort stable.
                unique case (1'b1)
                    cmp_gt: begin
                        mem_d[j_q]            = cmp_b;
                        mem_d[j_q + IW'(1)]   = cmp_a;
                        if (swap_cnt_q != '1) begin
                            swap_cnt_d = swap_cnt_q + CW'(1);
                        end
                    end
                    cmp_eq, cmp_lt: ;
                endcase

                if (j_q == IW'(N - 2) - i_q) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                    if (i_q == IW'(N - 2)) begin
                        state_d  = S_OUT;
                        rd_idx_d = '0;
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    if (rd_idx_q == IW'(N - 1)) begin
                        state_d  = S_LOAD;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: non-blocking assignments only, so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            // NOTE: the array is reset on purpose so a discarded batch never leaks into out_data.
            mem_q      <= '{default: '0};
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            i_q        <= i_d;
            j_q        <= j_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_SORT);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = (state_q == S_OUT) ? mem_q[rd_idx_q] : '0;
    assign out_last  = (state_q == S_OUT) && (rd_idx_q == IW'(N - 1));
    assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Randomized self-checking bench for cmp_sort_ctrl against a rank/inversion-count model.
module tb_cmp_sort_ctrl;
    import cmp_sort_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] swap_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  vals       [N];
    logic [W-1:0]  exp_sorted [N];
    int            exp_swaps;

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.N(N), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .swap_cnt  (swap_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_vals(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    endtask

    // Each value lands at its rank (ties broken by arrival order); swaps equal the inversion count.
    task automatic build_model();
        int rank;
        exp_swaps = 0;
        for (int a = 0; a < N; a++) begin
            rank = 0;
            for (int b = 0; b < N; b++)
                if (vals[b] < vals[a] || (vals[b] == vals[a] && b < a)) rank++;
            exp_sorted[rank] = vals[a];
            for (int b = a + 1; b < N; b++)
                if (vals[a] > vals[b]) exp_swaps++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_swap_cnt"},  32'(swap_cnt),  32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_batch(input string tag, input int gap_pct, input int stall_pct,
                             input bit hold_valid, input int abort_sort, input int abort_out);
        int idx, guard, cnt, k;
        bit v, acc, r;
        build_model();

        idx = 0; guard = 0;
        while (idx < N && guard < 200) begin
            guard++;
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? vals[idx] : W'($urandom);
            acc = v && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check({tag, "_load_cnt"}, 32'(idx), 32'(N));

        in_valid = hold_valid;
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            check({tag, "_sort_in_ready"}, 32'(in_ready), 32'd0);
            if (cnt == abort_sort) begin
                do_reset({tag, "_rst_sort"});
                return;
            end
            in_data = W'($urandom);
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(sort_cycles(N)));

        k = 0; guard = 0;
        while (k < N && guard < 200) begin
            guard++;
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_out_data"},  32'(out_data),  32'(exp_sorted[k]));
            check({tag, "_out_last"},  32'(out_last),  32'(k == N - 1));
            check({tag, "_swap_cnt"},  32'(swap_cnt),  32'(exp_swaps));
            check({tag, "_out_in_ready"}, 32'(in_ready), 32'd0);
            if (k == abort_out) begin
                do_reset({tag, "_rst_out"});
                return;
            end
            r = ($urandom_range(99) >= stall_pct);
            out_ready = r;
            in_data   = W'($urandom);
            @(posedge clk); #1;
            if (r) k++;
        end
        check({tag, "_out_cnt"}, 32'(k), 32'(N));

        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_post_swap_hold"}, 32'(swap_cnt),  32'(exp_swaps));
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_vals(4'd9, 4'd3, 4'd7, 4'd1);   run_batch("basic",    0,  0,  1'b0, -1, -1);
        set_vals(4'd0, 4'd1, 4'd2, 4'd3);   run_batch("sorted",   0,  0,  1'b0, -1, -1);
        set_vals(4'd15, 4'd10, 4'd5, 4'd0); run_batch("reversed", 0,  0,  1'b0, -1, -1);
        set_vals(4'd5, 4'd5, 4'd0, 4'd15);  run_batch("dups",     0,  0,  1'b0, -1, -1);
        set_vals(4'd9, 4'd3, 4'd7, 4'd1);   run_batch("bp_gaps",  50, 50, 1'b1, -1, -1);
        set_vals(4'd15, 4'd10, 4'd5, 4'd0); run_batch("abort_s",  0,  0,  1'b1,  3, -1);
        set_vals(4'd2, 4'd8, 4'd4, 4'd6);   run_batch("after_s",  0,  0,  1'b0, -1, -1);
        set_vals(4'd1, 4'd14, 4'd3, 4'd12); run_batch("abort_o",  0,  30, 1'b0, -1,  2);
        set_vals(4'd2, 4'd8, 4'd4, 4'd6);   run_batch("after_o",  30, 30, 1'b0, -1, -1);

        for (int t = 0; t < 40; t++) begin
            set_vals(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            run_batch("rand", $urandom_range(60), $urandom_range(60), 1'($urandom_range(1)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
